// File: rtl/branch_resolve_unit_pkg.sv
// ============================================================================
// Module : branch_resolve_unit_pkg
// Brief  : Shared widths, PC increment and prediction record.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package branch_resolve_unit_pkg;

  localparam int PC_W_DEF  = 32;
  localparam int IDX_W_DEF = 10;
  localparam int CNT_W_DEF = 32;
  localparam int c_pc_inc  = 4;

  typedef struct packed {
    logic                valid;
    logic [PC_W_DEF-1:0] pc;
    logic                pred_taken;
    logic [PC_W_DEF-1:0] pred_target;
  } pred_info_t;

endpackage

`default_nettype wire

// File: rtl/branch_resolve_unit_pred_stage_reg.sv
// ============================================================================
// Module : pred_stage_reg
// Brief  : Prediction pipeline register with stall hold and flush (flush wins).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pred_stage_reg
  import branch_resolve_unit_pkg::*;
#(
  parameter type INFO_T = pred_info_t
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  stall_i,
  input  logic  flush_i,
  input  INFO_T d_i,
  output INFO_T q_o
);

  INFO_T info_d;
  INFO_T info_q;

  always_comb begin
    info_d = stall_i ? info_q : d_i;
    if (flush_i) begin
      info_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      info_q <= '0;
    end else begin
      info_q <= info_d;
    end
  end

  assign q_o = info_q;

endmodule

`default_nettype wire

// File: rtl/branch_resolve_unit.sv
// ============================================================================
// Module : branch_resolve_unit
// Brief  : Carries fetch predictions to E, resolves them, trains and counts.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_F,
  input  logic [PC_W-1:0]  pc_F,
  input  logic [1:0]       predict_F,
  input  logic [PC_W-1:0]  pred_target_F,
  input  logic             stall_D,
  input  logic             flush_D,
  input  logic             flush_E,
  input  logic             branch_E,
  input  logic             jump_E,
  input  logic             take_E,
  input  logic [PC_W-1:0]  target_E,
  output logic             mispredict_E,
  output logic [PC_W-1:0]  redirect_pc_E,
  output logic             upd_branch,
  output logic             upd_jump,
  output logic             upd_take,
  output logic [IDX_W-1:0] upd_idx,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] miss_count
);

  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
  } info_t;

  info_t           w_info_f;
  info_t           w_info_d;
  info_t           w_info_e;
  logic            w_unused;
  logic [PC_W-1:0] w_pc_plus4;
  logic            w_tgt_diff;
  logic [CNT_W-1:0] br_d, br_q;
  logic [CNT_W-1:0] miss_d, miss_q;

  // Only the direction bit of the 2-bit counter matters downstream.
  assign w_unused = predict_F[0];

  assign w_info_f = '{valid: valid_F, pc: pc_F, pred_taken: predict_F[1],
                      pred_target: pred_target_F};

  pred_stage_reg #(.INFO_T(info_t)) u_stage_d (
    .clk     (clk),
    .rst     (rst),
    .stall_i (stall_D),
    .flush_i (flush_D),
    .d_i     (w_info_f),
    .q_o     (w_info_d)
  );

  pred_stage_reg #(.INFO_T(info_t)) u_stage_e (
    .clk     (clk),
    .rst     (rst),
    .stall_i (stall_D),
    .flush_i (flush_E),
    .d_i     (w_info_d),
    .q_o     (w_info_e)
  );

  assign w_pc_plus4 = w_info_e.pc + PC_W'(c_pc_inc);
  assign w_tgt_diff = (w_info_e.pred_target != target_E);

  always_comb begin
    mispredict_E  = 1'b0;
    redirect_pc_E = '0;
    upd_branch    = 1'b0;
    upd_jump      = 1'b0;
    upd_take      = 1'b0;
    upd_idx       = '0;
    if (w_info_e.valid) begin
      upd_branch = branch_E & ~jump_E;
      upd_jump   = jump_E;
      upd_take   = jump_E | take_E;
      upd_idx    = w_info_e.pc[IDX_W+1:2];
      // Jump takes priority so an illegal branch+jump encoding resolves as a jump.
      if (jump_E) begin
        mispredict_E  = ~w_info_e.pred_taken | w_tgt_diff;
        redirect_pc_E = target_E;
      end else if (branch_E) begin
        mispredict_E  = (take_E != w_info_e.pred_taken) |
                        (take_E & w_info_e.pred_taken & w_tgt_diff);
        redirect_pc_E = take_E ? target_E : w_pc_plus4;
      end else begin
        mispredict_E  = w_info_e.pred_taken;
        redirect_pc_E = w_pc_plus4;
      end
    end
  end

  // Counting is gated by stall so an instruction parked in E is seen once.
  always_comb begin
    br_d   = br_q;
    miss_d = miss_q;
    if (!stall_D) begin
      if ((upd_branch | upd_jump) && !(&br_q)) begin
        br_d = br_q + CNT_W'(1);
      end
      if (mispredict_E && !(&miss_q)) begin
        miss_d = miss_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_q   <= '0;
      miss_q <= '0;
    end else begin
      br_q   <= br_d;
      miss_q <= miss_d;
    end
  end

  assign br_count   = br_q;
  assign miss_count = miss_q;

endmodule

`default_nettype wire
